rover_cpu_vjtag_host_master: RTL and testbench
==============================================

// Module: rover_cpu_vjtag_host_master
// PURPOSE
//  Initiator end of the CPU's 2-bit-IR virtual-JTAG debug link. Drives the target's
//  tck/tdi/ir_in and uir/cdr/sdr/udr/rti strobes, and samples its tdo.
//  Each command runs one IR load (optional), one DR scan and one return to RTI.
//  The captured DR is returned on a valid/ready response port.
//  Used as the on-chip debug master and as the simulation driver for the debug module.
// PARAMETERS
//  DR_WIDTH  38  scan length in bits; >= 2
//  IR_WIDTH  2   virtual IR width
//  TCK_DIV   1   tck half-period in clk cycles; >= 1
// PORTS
//  clk          in   1         system clock; all logic on rising edge
//  reset        in   1         asynchronous, active-high reset
//  cmd_valid    in   1         command request
//  cmd_ready    out  1         command accept; registered
//  cmd_ir       in   IR_WIDTH  IR value to load
//  cmd_skip_ir  in   1         1 = skip the UIR phase and keep the current vj_ir_in
//  cmd_data     in   DR_WIDTH  DR word to shift in, LSB first
//  rsp_valid    out  1         captured DR is available
//  rsp_ready    in   1         response accept
//  rsp_data     out  DR_WIDTH  captured tdo bits; bit0 = first bit shifted
//  vj_tck       out  1         generated scan clock
//  vj_tdi       out  1         serial data to the target
//  vj_tdo       in   1         serial data from the target
//  vj_ir_in     out  IR_WIDTH  virtual IR value
//  vj_uir / vj_cdr / vj_sdr / vj_udr / vj_rti  out  1 each  virtual-state strobes
//  busy         out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset (async, all outputs): cmd_ready=0, rsp_valid=0, rsp_data=0, vj_tck=0, vj_tdi=0,
//   vj_ir_in=0, uir/cdr/sdr/udr=0, vj_rti=1, busy=0, FSM=IDLE.
//   cmd_ready rises 1 clk after reset deasserts.
//  Reset mid-scan: the in-flight command is dropped and no response is issued.
//  FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
//   If cmd_skip_ir=1, IDLE goes directly to CDR.
//  Timing:
//   - One tck period is 2*TCK_DIV clk cycles: tck low for the first TCK_DIV, high for the second.
//   - UIR, CDR, UDR and RTI last one period each; SDR lasts DR_WIDTH periods.
//   - Each strobe is high for the whole period(s) of its state and low otherwise.
//   - vj_rti is high in IDLE, RTI and RESP.
//  Accept: cmd_ready=1 only in IDLE. On cmd_valid&cmd_ready (cycle 0):
//   - cmd_data is latched into the shift register;
//   - cmd_ir is latched into vj_ir_in unless skip is set;
//   - cmd_ready drops at cycle 1 and the first state begins at cycle 1.
//  vj_ir_in changes only on an accepted non-skip command and holds between commands.
//  SDR shifting:
//   - vj_tdi = sr[0] is updated on the clk edge where tck falls (and at SDR entry).
//   - vj_tdo is sampled on the clk edge where tck rises.
//   - At that edge, sr <= {tdo, sr[DR_WIDTH-1:1]}.
//   - After DR_WIDTH rises, sr holds the capture.
//   - vj_tdi returns to 0 outside SDR.
//  Latency: rsp_valid rises at cycle 1 + (DR_WIDTH+4)*2*TCK_DIV, or
//   1 + (DR_WIDTH+3)*2*TCK_DIV with skip (85 / 83 at defaults).
//  Response:
//   - rsp_data is loaded from sr on RESP entry.
//   - rsp_valid and rsp_data hold stable until rsp_valid&rsp_ready.
//   - The FSM then returns to IDLE and cmd_ready=1 on the next clk.
//   - rsp_ready=1 in the RESP cycle gives rsp_valid for exactly 1 clk.
//  Simultaneity: a command cannot be accepted while a response is pending (no overlap).
//   cmd_valid held across busy is accepted on the first IDLE cycle.
//  tck is always 0 in IDLE and RESP; no free-running tck.
// TESTING
//  1. Loopback (vj_tdo=vj_tdi), cmd_data=38'h2A_5A5A_A5A5, ir=2'b10, TCK_DIV=1
//     -> rsp_data=38'h2A_5A5A_A5A5 at cycle 85; vj_ir_in=2'b10;
//     uir/cdr/sdr/udr high 2/2/76/2 clks.
//  2. vj_tdo tied 1, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF; vj_tdi stays 0 throughout.
//  3. cmd_skip_ir=1 after a load of ir=2'b01 -> vj_uir never pulses;
//     vj_ir_in stays 2'b01; rsp_valid at cycle 83.
//  4. rsp_ready held 0 for 20 clks while cmd_valid=1
//     -> rsp_data stable, cmd_ready=0 throughout; second command accepted 1 clk after the handshake.
//  5. TCK_DIV=3: tck high/low 3 clks each; tdo sampled only on rising edges
//     (bench flips tdo mid-high-phase; sampled value = value at the rise).
//  6. Assert reset during SDR bit 17 -> all outputs at reset values within the same cycle;
//     no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/rover_cpu_vjtag_host_master_if.sv
// Command/response handshake bundle for the virtual-JTAG host master.
// The requester uses the master modport; the scan engine uses the slave modport.
interface rover_cpu_vjtag_host_master_if #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic                cmd_skip_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_skip_ir,
    output cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_skip_ir,
    input  cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/rover_cpu_vjtag_host_master.sv
// Initiator of the CPU virtual-JTAG debug link: per command, optional IR load, one DR scan,
// return to RTI, then the captured DR is offered on the response port.
module rover_cpu_vjtag_host_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rover_cpu_vjtag_host_master_if.slave host_io,
  output logic                vj_tck_o,
  output logic                vj_tdi_o,
  input  logic                vj_tdo_i,
  output logic [IR_WIDTH-1:0] vj_ir_in_o,
  output logic                vj_uir_o,
  output logic                vj_cdr_o,
  output logic                vj_sdr_o,
  output logic                vj_udr_o,
  output logic                vj_rti_o,
  output logic                busy_o
);

  localparam int unsigned DivW = $clog2(2 * TCK_DIV);
  localparam int unsigned BitW = $clog2(DR_WIDTH);

  // div_q counts clk cycles within one tck period; tck is high for the upper half.
  localparam logic [DivW-1:0] DivLast = DivW'(2 * TCK_DIV - 1);
  localparam logic [DivW-1:0] DivRise = DivW'(TCK_DIV - 1);
  localparam logic [DivW-1:0] DivHigh = DivW'(TCK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRti,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic scan_active;
  logic period_end;
  logic tck_rise;
  logic accept;

  assign scan_active = (state_q == StUir) || (state_q == StCdr) || (state_q == StSdr) ||
                       (state_q == StUdr) || (state_q == StRti);
  assign period_end  = (div_q == DivLast);
  // The clk edge that ends this cycle is the one on which tck goes high.
  assign tck_rise    = (div_q == DivRise);
  assign accept      = (state_q == StIdle) && host_io.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    tdi_d       = tdi_q;
    ir_d        = ir_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (scan_active) begin
      div_d = period_end ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d  = host_io.cmd_data;
          div_d = '0;
          if (host_io.cmd_skip_ir) begin
            state_d = StCdr;
          end else begin
            ir_d    = host_io.cmd_ir;
            state_d = StUir;
          end
        end
      end
      StUir: begin
        if (period_end) state_d = StCdr;
      end
      StCdr: begin
        if (period_end) begin
          state_d = StSdr;
          bit_d   = '0;
          tdi_d   = sr_q[0];
        end
      end
      StSdr: begin
        if (tck_rise) sr_d = {vj_tdo_i, sr_q[DR_WIDTH-1:1]};
        // sr_q was already shifted at this period's rise, so sr_q[0] is the next bit out.
        if (period_end) begin
          if (bit_q == BitLast) begin
            state_d = StUdr;
            tdi_d   = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
            tdi_d = sr_q[0];
          end
        end
      end
      StUdr: begin
        if (period_end) state_d = StRti;
      end
      StRti: begin
        if (period_end) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sr_q;
        end
      end
      StResp: begin
        if (host_io.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      tdi_q       <= 1'b0;
      ir_q        <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      tdi_q       <= tdi_d;
      ir_q        <= ir_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign host_io.cmd_ready = cmd_ready_q;
  assign host_io.rsp_valid = rsp_valid_q;
  assign host_io.rsp_data  = rsp_data_q;

  assign vj_tck_o   = scan_active && (div_q >= DivHigh);
  assign vj_tdi_o   = tdi_q;
  assign vj_ir_in_o = ir_q;
  assign vj_uir_o   = (state_q == StUir);
  assign vj_cdr_o   = (state_q == StCdr);
  assign vj_sdr_o   = (state_q == StSdr);
  assign vj_udr_o   = (state_q == StUdr);
  assign vj_rti_o   = (state_q == StIdle) || (state_q == StRti) || (state_q == StResp);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_rover_cpu_vjtag_host_master.sv
// Scoreboard bench for the virtual-JTAG host master: default instance plus a TCK_DIV=3 one.
module tb_rover_cpu_vjtag_host_master;

  localparam int unsigned DrW = 38;
  localparam int unsigned Dr3 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rover_cpu_vjtag_host_master_if #(.DR_WIDTH(DrW), .IR_WIDTH(2)) hif ();
  rover_cpu_vjtag_host_master_if #(.DR_WIDTH(Dr3), .IR_WIDTH(2)) hif3 ();

  logic       tck, tdi, tdo, uir, cdr, sdr, udr, rti, busy;
  logic [1:0] ir_in;
  logic       loop_mode = 1'b1;
  assign tdo = loop_mode ? tdi : 1'b1;

  logic       tck3, tdi3, tdo3, uir3, cdr3, sdr3, udr3, rti3, busy3;
  logic [1:0] ir_in3;

  rover_cpu_vjtag_host_master #(.DR_WIDTH(DrW), .IR_WIDTH(2), .TCK_DIV(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .host_io(hif),
    .vj_tck_o(tck), .vj_tdi_o(tdi), .vj_tdo_i(tdo), .vj_ir_in_o(ir_in),
    .vj_uir_o(uir), .vj_cdr_o(cdr), .vj_sdr_o(sdr), .vj_udr_o(udr), .vj_rti_o(rti),
    .busy_o(busy)
  );

  rover_cpu_vjtag_host_master #(.DR_WIDTH(Dr3), .IR_WIDTH(2), .TCK_DIV(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .host_io(hif3),
    .vj_tck_o(tck3), .vj_tdi_o(tdi3), .vj_tdo_i(tdo3), .vj_ir_in_o(ir_in3),
    .vj_uir_o(uir3), .vj_cdr_o(cdr3), .vj_sdr_o(sdr3), .vj_udr_o(udr3), .vj_rti_o(rti3),
    .busy_o(busy3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DrW-1:0] exp_q[$];
  logic [Dr3-1:0] exp3_q[$];

  int             acc_cyc, hs_cyc, lat;
  logic [DrW-1:0] got_data;
  int             c_uir, c_cdr, c_sdr, c_udr, c_tdi1, stable_bad;
  logic           post_valid, post_ready;

  function automatic logic [49:0] dut_state();
    return {hif.cmd_ready, hif.rsp_valid, hif.rsp_data, tck, tdi, ir_in,
            uir, cdr, sdr, udr, rti, busy};
  endfunction

  localparam logic [49:0] RstVec = {1'b0, 1'b0, {DrW{1'b0}}, 1'b0, 1'b0, 2'b00,
                                    4'b0000, 1'b1, 1'b0};

  // Called at a negedge; returns at the negedge of cycle 1 (first scan cycle).
  task automatic issue_cmd(input logic [1:0] ir, input logic skip, input logic [DrW-1:0] data,
                           input logic [DrW-1:0] exp, input bit keep_valid);
    int t = 0;
    hif.cmd_ir      = ir;
    hif.cmd_skip_ir = skip;
    hif.cmd_data    = data;
    hif.cmd_valid   = 1'b1;
    while (hif.cmd_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (!keep_valid) hif.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect_rsp(input int hold);
    int t = 0;
    c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_tdi1 = 0;
    while (t < 400) begin
      if (hif.rsp_valid === 1'b1) break;
      if (uir === 1'b1) c_uir++;
      if (cdr === 1'b1) c_cdr++;
      if (sdr === 1'b1) c_sdr++;
      if (udr === 1'b1) c_udr++;
      if (tdi === 1'b1) c_tdi1++;
      @(negedge clk);
      t++;
    end
    lat        = cyc - acc_cyc;
    got_data   = hif.rsp_data;
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (hif.rsp_valid !== 1'b1 || hif.rsp_data !== got_data || hif.cmd_ready !== 1'b0)
        stable_bad++;
    end
    hif.rsp_ready = 1'b1;
    hs_cyc        = cyc;
    @(posedge clk);
    #1;
    hif.rsp_ready = 1'b0;
    @(negedge clk);
    post_valid = hif.rsp_valid;
    post_ready = hif.cmd_ready;
  endtask

  task automatic test_reset();
    n_checks++;
    if (dut_state() !== RstVec) $display("FAIL reset_values got %h want %h", dut_state(), RstVec);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hif.cmd_ready !== 1'b0) $display("FAIL cmd_ready_early got %b want 0", hif.cmd_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (hif.cmd_ready !== 1'b1) $display("FAIL cmd_ready_rise got %b want 1", hif.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_loopback();
    logic [DrW-1:0] e;
    loop_mode = 1'b1;
    issue_cmd(2'b10, 1'b0, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5, 1'b0);
    collect_rsp(0);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL loop_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e) $display("FAIL loop_data got %h want %h", got_data, e);
      else n_pass++;
    end
    n_checks++;
    if (lat !== 85) $display("FAIL loop_latency got %0d want 85", lat); else n_pass++;
    n_checks++;
    if (ir_in !== 2'b10) $display("FAIL loop_ir got %b want 10", ir_in); else n_pass++;
    n_checks++;
    if ({c_uir, c_cdr, c_sdr, c_udr} !== {32'd2, 32'd2, 32'd76, 32'd2})
      $display("FAIL loop_strobes got %0d/%0d/%0d/%0d want 2/2/76/2", c_uir, c_cdr, c_sdr, c_udr);
    else n_pass++;
    n_checks++;
    if (post_valid !== 1'b0) $display("FAIL rsp_one_clk got %b want 0", post_valid);
    else n_pass++;
    n_checks++;
    if (post_ready !== 1'b1) $display("FAIL ready_after_rsp got %b want 1", post_ready);
    else n_pass++;
  endtask

  task automatic test_tdo_high();
    logic [DrW-1:0] e;
    loop_mode = 1'b0;
    issue_cmd(2'b11, 1'b0, '0, 38'h3F_FFFF_FFFF, 1'b0);
    collect_rsp(0);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL ones_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e) $display("FAIL ones_data got %h want %h", got_data, e);
      else n_pass++;
    end
    n_checks++;
    if (c_tdi1 !== 0) $display("FAIL tdi_zero got %0d high cycles want 0", c_tdi1);
    else n_pass++;
    loop_mode = 1'b1;
  endtask

  task automatic test_skip_ir();
    logic [DrW-1:0] e;
    issue_cmd(2'b01, 1'b0, 38'h15_0F0F_3C3C, 38'h15_0F0F_3C3C, 1'b0);
    collect_rsp(0);
    void'(exp_q.pop_front());
    issue_cmd(2'b11, 1'b1, 38'h0A_1234_5678, 38'h0A_1234_5678, 1'b0);
    collect_rsp(0);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL skip_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e) $display("FAIL skip_data got %h want %h", got_data, e);
      else n_pass++;
    end
    n_checks++;
    if (c_uir !== 0) $display("FAIL skip_no_uir got %0d want 0", c_uir); else n_pass++;
    n_checks++;
    if (ir_in !== 2'b01) $display("FAIL skip_ir_hold got %b want 01", ir_in); else n_pass++;
    n_checks++;
    if (lat !== 83) $display("FAIL skip_latency got %0d want 83", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DrW-1:0] e;
    issue_cmd(2'b10, 1'b0, 38'h01_8001_0003, 38'h01_8001_0003, 1'b1);
    collect_rsp(20);
    n_checks++;
    if (stable_bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", stable_bad);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL hold_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e) $display("FAIL hold_data got %h want %h", got_data, e);
      else n_pass++;
    end
    issue_cmd(2'b10, 1'b0, 38'h01_8001_0003, 38'h01_8001_0003, 1'b0);
    n_checks++;
    if (acc_cyc - hs_cyc !== 1)
      $display("FAIL b2b_accept got %0d clks want 1", acc_cyc - hs_cyc);
    else n_pass++;
    collect_rsp(0);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL b2b_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e || lat !== 85)
        $display("FAIL b2b_data got %h lat %0d want %h lat 85", got_data, lat, e);
      else n_pass++;
    end
  endtask

  task automatic test_tck_div3();
    logic [Dr3-1:0] pat = 8'b1011_0010;
    logic [Dr3-1:0] e;
    logic           prev_tck = 1'b0;
    logic           prev_sdr = 1'b0;
    bit             seen_edge = 1'b0;
    int             k = 0, run = 0, bad_run = 0, rises = 0, t = 0, l3;
    hif3.cmd_ir      = 2'b10;
    hif3.cmd_skip_ir = 1'b0;
    hif3.cmd_data    = '0;
    hif3.cmd_valid   = 1'b1;
    while (hif3.cmd_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    exp3_q.push_back(pat);
    @(posedge clk);
    #1 hif3.cmd_valid = 1'b0;
    t = 0;
    while (hif3.rsp_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
      if (tck3 === prev_tck) run++;
      else begin
        if (seen_edge && run != 3) bad_run++;
        if (tck3 === 1'b1) rises++;
        seen_edge = 1'b1;
        run = 1;
      end
      // tdo is valid through the rise, then inverted for the rest of the high phase.
      if (sdr3 === 1'b1) begin
        if (prev_sdr && prev_tck && !tck3) k++;
        tdo3 = tck3 ? ~pat[k] : pat[k];
      end else tdo3 = 1'b0;
      prev_tck = tck3;
      prev_sdr = sdr3;
    end
    l3 = cyc - acc_cyc;
    n_checks++;
    if (exp3_q.size() == 0) $display("FAIL div3_data no expected entry, got %h", hif3.rsp_data);
    else begin
      e = exp3_q.pop_front();
      if (hif3.rsp_data !== e) $display("FAIL div3_data got %h want %h", hif3.rsp_data, e);
      else n_pass++;
    end
    n_checks++;
    if (l3 !== 73) $display("FAIL div3_latency got %0d want 73", l3); else n_pass++;
    n_checks++;
    if (bad_run !== 0 || rises !== 12)
      $display("FAIL div3_tck got %0d bad runs %0d rises want 0 bad runs 12 rises", bad_run, rises);
    else n_pass++;
    hif3.rsp_ready = 1'b1;
    @(posedge clk);
    #1 hif3.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [DrW-1:0] e;
    logic           prev_tck = 1'b0;
    int             rises = 0, t = 0, seen = 0;
    loop_mode = 1'b1;
    issue_cmd(2'b10, 1'b0, 38'h33_CCCC_5555, 38'h33_CCCC_5555, 1'b0);
    while (!(sdr === 1'b1 && rises == 17 && tck === 1'b1) && t < 300) begin
      if (sdr === 1'b1 && tck === 1'b1 && prev_tck === 1'b0) rises++;
      prev_tck = tck;
      if (sdr === 1'b1 && rises == 17 && tck === 1'b1) break;
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 300) $display("FAIL mid_reach got %0d rises want 17", rises); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_state() !== RstVec) $display("FAIL mid_reset got %h want %h", dut_state(), RstVec);
    else n_pass++;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hif.rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL mid_no_rsp got %0d valid cycles want 0", seen); else n_pass++;
    issue_cmd(2'b01, 1'b0, 38'h12_3456_789A, 38'h12_3456_789A, 1'b0);
    collect_rsp(0);
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL post_reset_data no expected entry, got %h", got_data);
    else begin
      e = exp_q.pop_front();
      if (got_data !== e || lat !== 85)
        $display("FAIL post_reset_data got %h lat %0d want %h lat 85", got_data, lat, e);
      else n_pass++;
    end
  endtask

  initial begin
    hif.cmd_valid    = 1'b0;
    hif.cmd_ir       = '0;
    hif.cmd_skip_ir  = 1'b0;
    hif.cmd_data     = '0;
    hif.rsp_ready    = 1'b0;
    hif3.cmd_valid   = 1'b0;
    hif3.cmd_ir      = '0;
    hif3.cmd_skip_ir = 1'b0;
    hif3.cmd_data    = '0;
    hif3.rsp_ready   = 1'b0;
    tdo3             = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_loopback();
    test_tdo_high();
    test_skip_ir();
    test_back_to_back();
    test_tck_div3();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
